// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan controller:
//   - active-low segment patterns for hex digits 0-F (bit 0 = a ... bit 6 = g)
//   - "everything off" constants for segments and anodes
//   - scan FSM state encoding
//   - display image record and its reset value
//   - leading-zero suppression helper
// -----------------------------------------------------------------------------
package seg_pkg;

    // Active-low patterns, written as {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic {
        BLANK = 1'b0,   // dead time, all anodes off
        SHOW  = 1'b1    // current digit driven
    } scan_state_t;

    // One complete display image; nibble i of digits belongs to digit i.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
    } image_t;

    // Display stays dark until the first image is committed.
    localparam image_t IMAGE_RESET = '{digits: 16'h0000, dp: 4'h0, blank: 4'hF, blink: 4'h0};

    // True when digit idx would be a leading zero: idx > 0 and every nibble
    // from idx up to the leftmost digit is zero. Digit 0 always shows.
    function automatic logic lz_dark(input logic [15:0] digits, input logic [1:0] idx);
        logic all_zero;
        all_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(idx) && digits[4*i +: 4] != 4'h0) begin
                all_zero = 1'b0;
            end
        end
        return (idx != 2'd0) && all_zero;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
// Purely combinational hex nibble to active-low seven-segment decoder.
// Ports:
//   nibble  in  4  hex value 0-F
//   seg     out 7  active-low segments, seg[0]=a ... seg[6]=g
// -----------------------------------------------------------------------------
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        unique case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. Images arrive over a valid/ready handshake into a pending buffer
// and are committed to the active buffer only at frame boundaries. Each digit
// slot starts with a blanking interval (all anodes off) to suppress ghosting.
// Ports:
//   clk         in  1   system clock
//   rst_n       in  1   asynchronous active-low reset
//   din_valid   in  1   requester presents a new image
//   din_ready   out 1   pending buffer free, image can be accepted
//   din_digits  in  16  nibble i drives digit i (digit 0 rightmost)
//   din_dp      in  4   decimal-point enable per digit
//   din_blank   in  4   force digit dark
//   din_blink   in  4   digit blinks
//   lz_en       in  1   leading-zero suppression, sampled live
//   seg         out 7   active-low segments, seg[0]=a ... seg[6]=g
//   dp          out 1   active-low decimal point
//   an          out 4   active-low anodes
//   frame_done  out 1   pulse on the last SHOW cycle of digit 3
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [15:0] din_digits,
    input  logic [3:0]  din_dp,
    input  logic [3:0]  din_blank,
    input  logic [3:0]  din_blink,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam int FC_W  = $clog2(BLINK_FRAMES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(BLINK_FRAMES - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;      // cycle within the digit slot
    logic [1:0]       idx_q, idx_d;      // digit currently scanned
    logic [FC_W-1:0]  fc_q, fc_d;        // frames in the current blink half-period
    logic             phase_q, phase_d;  // 1 = blinking digits are dark
    image_t           act_q, act_d;
    image_t           pend_q, pend_d;
    logic             pend_full_q, pend_full_d;

    logic             last_show;
    logic             frame_end;
    logic             xfer;
    logic             din_ready_d;
    logic             frame_done_d;

    logic [3:0]       nibble_d;
    logic [6:0]       seg_dec;
    logic             dark;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    // Next-state, buffering and handshake. Everything here is the value the
    // registers will hold after this edge; outputs below are derived from
    // these so that the registered outputs line up with the registered state.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves
        // it unassigned; otherwise synthesis infers a latch to hold the old value.
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        fc_d        = fc_q;
        phase_d     = phase_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        last_show = (state_q == SHOW) && (cnt_q == CNT_LAST);
        frame_end = last_show && (idx_q == 2'd3);
        xfer      = din_valid && din_ready;

        unique case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (last_show) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: state_d = BLANK;
        endcase

        if (frame_end) begin
            if (fc_q == FC_LAST) begin
                fc_d    = '0;
                phase_d = ~phase_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
            if (pend_full_q) begin
                act_d       = pend_q;
                pend_full_d = 1'b0;
            end
        end

        // A transfer needs an empty pending buffer, so it never collides with
        // a commit; one landing on frame_done waits for the next boundary.
        if (xfer) begin
            pend_d      = '{digits: din_digits, dp: din_dp, blank: din_blank, blink: din_blink};
            pend_full_d = 1'b1;
        end

        din_ready_d  = ~pend_full_d;
        frame_done_d = (state_d == SHOW) && (idx_d == 2'd3) && (cnt_d == CNT_LAST);
    end

    assign nibble_d = act_d.digits[{idx_d, 2'b00} +: 4];

    seg_hex_decode u_hex_decode (
        .nibble (nibble_d),
        .seg    (seg_dec)
    );

    // A dark digit keeps its slot timing; only the anode and segments stay off.
    always_comb begin
        dark  = act_d.blank[idx_d]
              | (act_d.blink[idx_d] & phase_d)
              | (lz_en & lz_dark(act_d.digits, idx_d));
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == SHOW && !dark) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = seg_dec;
            dp_d  = ~act_d.dp[idx_d];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order or other always blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            fc_q        <= '0;
            phase_q     <= 1'b0;
            act_q       <= IMAGE_RESET;
            // NOTE: the image buffers are plain registers, so resetting them is
            // cheap; clearing pend_full is what discards a pending image.
            pend_q      <= IMAGE_RESET;
            pend_full_q <= 1'b0;
            din_ready   <= 1'b1;
            frame_done  <= 1'b0;
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            fc_q        <= fc_d;
            phase_q     <= phase_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            din_ready   <= din_ready_d;
            frame_done  <= frame_done_d;
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with DIGIT_CYCLES=8, BLANK_CYCLES=2,
// BLINK_FRAMES=2 (32-cycle frames). A cycle-level reference model pushes the
// expected outputs for each clock edge into a scoreboard queue as inputs are
// driven; the entry is popped and compared once the DUT has produced that
// cycle. Directed checks against literal segment/anode values are added at
// key points.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * DC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] din_digits = 16'h0;
    logic [3:0]  din_dp = 4'h0;
    logic [3:0]  din_blank = 4'h0;
    logic [3:0]  din_blink = 4'h0;
    logic        lz_en = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    seg_scan_ctrl #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_digits (din_digits),
        .din_dp     (din_dp),
        .din_blank  (din_blank),
        .din_blink  (din_blink),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       rdy;
    } obs_t;

    obs_t exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    logic [15:0] m_dig, p_dig;
    logic [3:0]  m_dpm, m_blank, m_blink, p_dpm, p_blank, p_blink;
    bit          m_pf, m_phase;
    int          m_fc, m_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic lit(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
        chk({tag, "_an"}, 32'(an), 32'(a));
        chk({tag, "_seg"}, 32'(seg), 32'(s));
        chk({tag, "_dp"}, 32'(dp), 32'(d));
    endtask

    task automatic model_reset();
        m_dig = 16'h0; m_dpm = 4'h0; m_blank = 4'hF; m_blink = 4'h0;
        p_dig = 16'h0; p_dpm = 4'h0; p_blank = 4'h0; p_blink = 4'h0;
        m_pf = 1'b0; m_phase = 1'b0; m_fc = 0; m_c = 0;
        exp_q.delete();
    endtask

    // Expected outputs for frame position m_c with the current model image.
    function automatic obs_t model_out();
        obs_t o;
        int   d;
        int   pos;
        logic drk;
        d   = m_c / DC;
        pos = m_c % DC;
        drk = m_blank[d] | (m_blink[d] & m_phase)
            | (lz_en && d > 0 && (m_dig >> (4 * d)) == 16'h0);
        o.fd  = (m_c == FRAME - 1);
        o.rdy = !m_pf;
        if (pos >= BC && !drk) begin
            o.an  = ~(4'b0001 << d);
            o.seg = SEG_TBL[m_dig[4*d +: 4]];
            o.dp  = ~m_dpm[d];
        end else begin
            o.an  = 4'hF;
            o.seg = 7'h7F;
            o.dp  = 1'b1;
        end
        return o;
    endfunction

    // One clock edge: advance the model, queue its prediction, let the DUT
    // clock, then pop and compare. Called at a falling edge.
    task automatic step(output bit xfer);
        obs_t e;
        obs_t g;
        xfer = din_valid && !m_pf;
        if (m_c == FRAME - 1) begin
            if (m_pf) begin
                m_dig = p_dig; m_dpm = p_dpm; m_blank = p_blank; m_blink = p_blink;
                m_pf  = 1'b0;
            end
            m_fc++;
            if (m_fc == BF) begin
                m_fc    = 0;
                m_phase = !m_phase;
            end
        end
        if (xfer) begin
            p_dig = din_digits; p_dpm = din_dp; p_blank = din_blank; p_blink = din_blink;
            m_pf  = 1'b1;
        end
        m_c = (m_c + 1) % FRAME;
        exp_q.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
        g = {an, seg, dp, frame_done, din_ready};
        e = exp_q.pop_front();
        chk($sformatf("cycle%0d{an,seg,dp,fd,rdy}", m_c), 32'(g), 32'(e));
    endtask

    task automatic run(input int n);
        bit x;
        repeat (n) step(x);
    endtask

    task automatic run_to(input int c);
        bit x;
        int k;
        k = 0;
        while (m_c != c && k < FRAME) begin
            step(x);
            k++;
        end
    endtask

    task automatic send(input logic [15:0] dig, input logic [3:0] dpm,
                        input logic [3:0] blank, input logic [3:0] blink);
        bit x;
        int k;
        x = 1'b0;
        k = 0;
        din_valid = 1'b1; din_digits = dig; din_dp = dpm; din_blank = blank; din_blink = blink;
        while (!x && k < 4 * FRAME) begin
            step(x);
            k++;
        end
        din_valid = 1'b0;
        if (!x) begin
            tests_run++;
            tests_failed++;
            $error("FAIL send_timeout: observed no transfer expected transfer within %0d cycles", 4 * FRAME);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  lit0;
        int  lit1;
        bit  x;

        // Power-up reset: dark outputs, ready high.
        model_reset();
        repeat (2) @(negedge clk);
        lit("reset", 4'hF, 7'h7F, 1'b1);
        chk("reset_ready", 32'(din_ready), 32'd1);
        chk("reset_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        run(FRAME);

        // Plain image 1234 with dp on digit 0.
        send(16'h1234, 4'b0001, 4'h0, 4'h0);
        run_to(0);
        lit("t2_c0", 4'hF, 7'h7F, 1'b1);
        run(1);
        lit("t2_c1", 4'hF, 7'h7F, 1'b1);
        run(1);
        lit("t2_d0", 4'b1110, 7'b0011001, 1'b0);
        run_to(7);
        lit("t2_d0_end", 4'b1110, 7'b0011001, 1'b0);
        run_to(26);
        lit("t2_d3", 4'b0111, 7'b1111001, 1'b1);

        // Back-to-back images: second waits for the commit of the first.
        send(16'hABCD, 4'h0, 4'h0, 4'h0);
        chk("t3_ready_low", 32'(din_ready), 32'd0);
        send(16'h5678, 4'h0, 4'h0, 4'h0);
        run_to(5);
        lit("t3_first", 4'b1110, 7'h21, 1'b1);
        run_to(0);
        run_to(5);
        lit("t3_second", 4'b1110, 7'h00, 1'b1);

        // Leading-zero suppression.
        lz_en = 1'b1;
        send(16'h0050, 4'h0, 4'h0, 4'h0);
        run_to(0);
        run_to(5);
        lit("t4_d0", 4'b1110, 7'b1000000, 1'b1);
        run_to(13);
        lit("t4_d1", 4'b1101, 7'b0010010, 1'b1);
        run_to(21);
        lit("t4_d2", 4'hF, 7'h7F, 1'b1);
        run_to(29);
        lit("t4_d3", 4'hF, 7'h7F, 1'b1);
        send(16'h0000, 4'h0, 4'h0, 4'h0);
        run_to(0);
        run_to(5);
        lit("t4_zero_d0", 4'b1110, 7'b1000000, 1'b1);
        run_to(13);
        lit("t4_zero_d1", 4'hF, 7'h7F, 1'b1);
        lz_en = 1'b0;

        // Blink on digit 0: lit in half of 8 consecutive frames, digit 1 always.
        send(16'h1234, 4'h0, 4'h0, 4'b0001);
        run_to(0);
        lit0 = 0;
        lit1 = 0;
        for (int f = 0; f < 8; f++) begin
            run_to(5);
            if (an == 4'b1110) lit0++;
            run_to(13);
            if (an == 4'b1101) lit1++;
            run_to(0);
        end
        chk("t5_d0_lit_frames", 32'(lit0), 32'd4);
        chk("t5_d1_lit_frames", 32'(lit1), 32'd8);

        // Transfer on the frame_done cycle commits one frame later.
        send(16'h1111, 4'h0, 4'h0, 4'h0);
        run_to(0);
        run_to(FRAME - 1);
        chk("t6_fd", 32'(frame_done), 32'd1);
        din_valid = 1'b1; din_digits = 16'h9876; din_dp = 4'h0; din_blank = 4'h0; din_blink = 4'h0;
        step(x);
        din_valid = 1'b0;
        run_to(5);
        lit("t6_old", 4'b1110, 7'h79, 1'b1);
        run_to(0);
        run_to(5);
        lit("t6_new", 4'b1110, 7'h02, 1'b1);

        // Mid-frame reset during digit 2 SHOW discards pending image.
        send(16'h2222, 4'h0, 4'h0, 4'h0);
        run_to(0);
        send(16'h8888, 4'h0, 4'h0, 4'h0);
        run_to(18);
        lit("t1_pre", 4'b1011, 7'h24, 1'b1);
        rst_n = 1'b0;
        #1;
        lit("t1_rst", 4'hF, 7'h7F, 1'b1);
        chk("t1_rst_ready", 32'(din_ready), 32'd1);
        chk("t1_rst_fd", 32'(frame_done), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(FRAME);
        run_to(5);
        lit("t1_dark", 4'hF, 7'h7F, 1'b1);
        run_to(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
